// File: rtl/axi_lite_cmd_arbiter.sv
// axi_lite_cmd_arbiter
// Shares one AXI4-Lite master command port between NUM_REQ requesters.
// One grant at a time: a 1-cycle AXI_Start pulse, a wait for the rising edge
// of AXI_Done, then a 1-cycle rsp_valid pulse and the captured read data
// returned to the granted requester.
// Optional build macro AXI_ARB_FIXED_PRIO_EN: fixed priority (lowest index
// wins) instead of the default round-robin search.
module axi_lite_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [CNT_W-1:0]           txn_count,
  output logic                       AXI_Start,
  output logic                       AXI_WriteEn,
  output logic [ADDR_W-1:0]          AXI_Addr,
  output logic [DATA_W-1:0]          AXI_WData,
  input  logic [DATA_W-1:0]          AXI_RData,
  input  logic                       AXI_Done
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [0:0] {ST_ARB, ST_WAIT} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr[NUM_REQ];

  logic              done_q_reg;
  logic              done_rise;
  logic              win_found;
  logic [ID_W-1:0]   win_id;

  logic [NUM_REQ-1:0] ready_reg, ready_next;
  logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]  rdata_reg, rdata_next;
  logic [ID_W-1:0]    grant_reg, grant_next;
  logic [CNT_W-1:0]   txn_reg, txn_next;
  logic               start_reg, start_next;
  logic               write_reg, write_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [DATA_W-1:0]  wdata_reg, wdata_next;

  // Unpack the per-requester address and write-data slices
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // A level-high Done left over from the previous transaction is not a rise
  assign done_rise = AXI_Done & ~done_q_reg;

  // Done history register, updated every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) done_q_reg <= 1'b0;
    else        done_q_reg <= AXI_Done;
  end

`ifdef AXI_ARB_FIXED_PRIO_EN
  // Winner select: lowest-index valid request wins
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_reg;
  logic [ID_W:0]   rr_idx;

  // Winner select: first valid request searching upward from rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
      if (rr_idx >= (ID_W+1)'(NUM_REQ)) rr_idx = rr_idx - (ID_W+1)'(NUM_REQ);
      if (!win_found && req_valid[rr_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = rr_idx[ID_W-1:0];
      end
    end
  end

  // Round-robin pointer moves past the grantee once its transaction completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (state_reg == ST_WAIT && done_rise) begin
      if (grant_reg == ID_W'(NUM_REQ - 1)) rr_ptr_reg <= '0;
      else                                 rr_ptr_reg <= grant_reg + 1'b1;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_ARB;
    else        state_reg <= state_next;
  end

  // FSM next state: grant on any request, return to arbitration on done rise
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ARB:  if (win_found) state_next = ST_WAIT;
      ST_WAIT: if (done_rise) state_next = ST_ARB;
      default: state_next = ST_ARB;
    endcase
  end

  // FSM outputs: pulses default low, latched command/response values hold
  always_comb begin
    ready_next     = '0;
    start_next     = 1'b0;
    rsp_valid_next = '0;
    rdata_next     = rdata_reg;
    grant_next     = grant_reg;
    txn_next       = txn_reg;
    write_next     = write_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    case (state_reg)
      ST_ARB: begin
        if (win_found) begin
          ready_next = NUM_REQ'(1) << win_id;
          start_next = 1'b1;
          write_next = req_write[win_id];
          addr_next  = addr_arr[win_id];
          wdata_next = wdata_arr[win_id];
          grant_next = win_id;
        end
      end
      ST_WAIT: begin
        if (done_rise) begin
          rsp_valid_next = NUM_REQ'(1) << grant_reg;
          rdata_next     = AXI_RData;
          txn_next       = txn_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, all cleared by reset (an in-flight grant is dropped)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_reg     <= '0;
      start_reg     <= 1'b0;
      rsp_valid_reg <= '0;
      rdata_reg     <= '0;
      grant_reg     <= '0;
      txn_reg       <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      ready_reg     <= ready_next;
      start_reg     <= start_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
      grant_reg     <= grant_next;
      txn_reg       <= txn_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
    end
  end

  assign req_ready   = ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rdata_reg;
  assign busy        = (state_reg == ST_WAIT);
  assign grant_id    = grant_reg;
  assign txn_count   = txn_reg;
  assign AXI_Start   = start_reg;
  assign AXI_WriteEn = write_reg;
  assign AXI_Addr    = addr_reg;
  assign AXI_WData   = wdata_reg;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// tb_axi_lite_cmd_arbiter
// Directed bench with a behavioural AXI4-Lite master and a scoreboard of
// expected Start commands and responses. The counter is built 4 bits wide so
// its wrap to zero is reached in a handful of transactions.
module tb_axi_lite_cmd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic [CNT_W-1:0]          txn_count;
  logic                      AXI_Start;
  logic                      AXI_WriteEn;
  logic [ADDR_W-1:0]         AXI_Addr;
  logic [DATA_W-1:0]         AXI_WData;
  logic [DATA_W-1:0]         AXI_RData;
  logic                      AXI_Done;

  axi_lite_cmd_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .grant_id(grant_id), .txn_count(txn_count),
    .AXI_Start(AXI_Start), .AXI_WriteEn(AXI_WriteEn), .AXI_Addr(AXI_Addr),
    .AXI_WData(AXI_WData), .AXI_RData(AXI_RData), .AXI_Done(AXI_Done)
  );

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } start_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
  } rsp_t;

  start_t exp_start[$];
  rsp_t   exp_rsp[$];

  int          checks     = 0;
  int          failures   = 0;
  int          exp_txn    = 0;
  int          cyc        = 0;
  int          cur_id     = 0;
  int          start_seen = 0;
  int          last_rsp_cyc = -10;
  int          done_cyc   = -10;
  bit          chk_b2b    = 0;
  bit          auto_drop  = 1;
  bit          prev_start = 0;
  int          lat        = 5;
  int          clr_dly    = 0;
  logic [31:0] rd_cfg     = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_start(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_start.push_back('{id, wr, a, d});
  endtask

  task automatic issue(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[id]              = wr;
    req_addr[id*ADDR_W +: ADDR_W]  = a;
    req_wdata[id*DATA_W +: DATA_W] = d;
    req_valid[id]              = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_start.size() != 0 || exp_rsp.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_bound", 64'(n < 300), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (start_seen < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("start_wait_bound", 64'(n < 300), 64'd1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    exp_txn = 0;
    rst_n   = 1'b1;
  endtask

  // Behavioural AXI4-Lite master: Done rises lat cycles after Start and stays
  // high until clr_dly cycles after the next Start
  initial begin
    int cnt = 0;
    int clr = 0;
    AXI_Done  = 1'b0;
    AXI_RData = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        AXI_Done = 1'b0;
        cnt = 0;
        clr = 0;
      end else if (AXI_Start) begin
        cnt = lat;
        clr = clr_dly;
        if (clr_dly == 0) AXI_Done = 1'b0;
      end else begin
        if (clr > 0) begin
          clr--;
          if (clr == 0) AXI_Done = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            AXI_Done  = 1'b1;
            AXI_RData = rd_cfg;
            exp_rsp.push_back('{cur_id, rd_cfg});
            done_cyc  = cyc;
          end
        end
      end
    end
  end

  // Monitor: compares every Start and every response against the scoreboard
  initial begin
    start_t e;
    rsp_t   r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_start = 0;
      end else begin
        if (AXI_Start) begin
          chk("start_not_back_to_back", 64'(prev_start), 64'd0);
          chk("start_expected", 64'(exp_start.size() != 0), 64'd1);
          if (exp_start.size() != 0) begin
            e = exp_start.pop_front();
            $display("start: id=%0d wr=%0d addr=%0h wdata=%0h cyc=%0d", grant_id, AXI_WriteEn, AXI_Addr, AXI_WData, cyc);
            chk("start_grant_id", 64'(grant_id), 64'(e.id));
            chk("start_writeen", 64'(AXI_WriteEn), 64'(e.wr));
            chk("start_addr", 64'(AXI_Addr), 64'(e.addr));
            chk("start_wdata", 64'(AXI_WData), 64'(e.wdata));
            chk("start_req_ready", 64'(req_ready), 64'(4'b0001 << e.id));
            chk("start_busy", 64'(busy), 64'd1);
            if (chk_b2b) chk("start_after_rsp", 64'(cyc), 64'(last_rsp_cyc + 1));
            cur_id = e.id;
          end
          start_seen++;
          if (auto_drop) begin
            for (int i = 0; i < NUM_REQ; i++)
              if (req_ready[i]) req_valid[i] = 1'b0;
          end
        end else if (req_ready != '0) begin
          chk("ready_without_start", 64'(req_ready), 64'd0);
        end
        if (rsp_valid != '0) begin
          chk("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
          if (exp_rsp.size() != 0) begin
            r = exp_rsp.pop_front();
            exp_txn = (exp_txn + 1) % (1 << CNT_W);
            $display("rsp: valid=%b rdata=%0h txn_count=%0d cyc=%0d", rsp_valid, rsp_rdata, txn_count, cyc);
            chk("rsp_onehot", 64'(rsp_valid), 64'(4'b0001 << r.id));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
            chk("rsp_txn_count", 64'(txn_count), 64'(exp_txn));
            chk("rsp_latency", 64'(cyc), 64'(done_cyc + 1));
          end
          last_rsp_cyc = cyc;
        end
        prev_start = AXI_Start;
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int n_order;
    int order[5];
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_start", 64'(AXI_Start), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_txn_count", 64'(txn_count), 64'd0);
    chk("reset_addr", 64'(AXI_Addr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single write from requester 0
    lat = 5; clr_dly = 0; rd_cfg = 32'h0000_0011;
    expect_start(0, 1'b1, 32'h10, 32'hA5);
    issue(0, 1'b1, 32'h10, 32'hA5);
    @(negedge clk);
    chk("t1_start_latency", 64'(AXI_Start), 64'd1);
    wait_idle();
    chk("t1_txn_count", 64'(txn_count), 64'd1);

    // 2: read from requester 2
    rd_cfg = 32'hDEAD_BEEF;
    expect_start(2, 1'b0, 32'h40, 32'h0);
    issue(2, 1'b0, 32'h40, 32'h0);
    wait_idle();
    chk("t2_grant_id", 64'(grant_id), 64'd2);
    chk("t2_rdata_held", 64'(rsp_rdata), 64'hDEAD_BEEF);

    // 3: all requesters held valid, fresh arbitration state
    do_reset();
    @(negedge clk);
    lat = 3; rd_cfg = 32'h3333; auto_drop = 0;
`ifdef AXI_ARB_FIXED_PRIO_EN
    n_order = 3;
    order = '{0, 0, 0, 0, 0};
`else
    n_order = 5;
    order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      req_write[i] = i[0];
      req_addr[i*ADDR_W +: ADDR_W]  = 32'h100 + 32'(i * 4);
      req_wdata[i*DATA_W +: DATA_W] = 32'h1000 + 32'(i);
    end
    for (int k = 0; k < n_order; k++)
      expect_start(order[k], order[k][0], 32'h100 + 32'(order[k] * 4), 32'h1000 + 32'(order[k]));
    start_seen = 0;
    req_valid  = 4'hF;
    wait_starts(n_order);
    @(negedge clk);
    req_valid = '0;
    wait_idle();
    auto_drop = 1;

    // 4: request arrives mid-WAIT; Done kept high into the next WAIT
    lat = 6; clr_dly = 2; rd_cfg = 32'h4444;
    expect_start(0, 1'b0, 32'h80, 32'h0);
    issue(0, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    chk_b2b = 1;
    @(negedge clk);
    expect_start(1, 1'b1, 32'h84, 32'h55);
    start_seen = 0;
    issue(1, 1'b1, 32'h84, 32'h55);
    wait_starts(1);
    chk_b2b = 0;
    @(negedge clk);
    req_valid[3] = 1'b1;
    @(negedge clk);
    req_valid[3] = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);

    // 5: reset during WAIT drops the grant silently
    lat = 8; clr_dly = 0; rd_cfg = 32'h5555;
    expect_start(2, 1'b0, 32'h90, 32'h0);
    start_seen = 0;
    issue(2, 1'b0, 32'h90, 32'h0);
    wait_starts(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_start", 64'(AXI_Start), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_grant_id", 64'(grant_id), 64'd0);
    chk("t5_txn_count", 64'(txn_count), 64'd0);
    chk("t5_addr", 64'(AXI_Addr), 64'd0);
    chk("t5_wdata", 64'(AXI_WData), 64'd0);
    chk("t5_writeen", 64'(AXI_WriteEn), 64'd0);
    exp_txn = 0;
    rst_n   = 1'b1;
    repeat (10) @(negedge clk);
    lat = 4; rd_cfg = 32'h6666;
    expect_start(1, 1'b1, 32'hA4, 32'h77);
    expect_start(3, 1'b0, 32'hAC, 32'h0);
    issue(1, 1'b1, 32'hA4, 32'h77);
    issue(3, 1'b0, 32'hAC, 32'h0);
    wait_idle();
    chk("t5_txn_after_reset", 64'(txn_count), 64'd2);

    // 6: counter wrap (4-bit build): 2 + 15 completions -> 1
    lat = 3; rd_cfg = 32'h7777;
    for (int i = 0; i < 15; i++) begin
      rd_cfg = 32'h7000 + 32'(i);
      expect_start(i % 4, 1'b1, 32'h200 + 32'(i), 32'h300 + 32'(i));
      issue(i % 4, 1'b1, 32'h200 + 32'(i), 32'h300 + 32'(i));
      wait_idle();
    end
    chk("t6_txn_wrapped", 64'(txn_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
